// File: rtl/sprite_desc_writer.sv
// sprite_desc_writer: memory-mapped shadow registers for the three packed
// sprite descriptors (p1, p2, stage). The shadows are copied to the active
// outputs atomically at the start of vertical sync.
// Optional feature macro: SPRITE_AUTO_COMMIT_EN. When defined, any shadow
// write also requests a commit.
module sprite_desc_writer #(
  parameter logic [12:0] BASE_ADDR   = 13'h1F00,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [12:0] address,
  input  logic [31:0] data_in,
  input  logic        wren,
  output logic        hit,
  output logic [31:0] data_out,
  input  logic        vga_vs,
  output logic [63:0] p1VGA,
  output logic [63:0] p2VGA,
  output logic [63:0] stageVGA,
  output logic        frame_tick
);

  typedef enum logic {IDLE, PENDING} state_t;

  state_t                 state;
  logic [31:0]            shadow [6];
  logic [15:0]            frame_cnt;
  logic [SYNC_STAGES-1:0] vs_sync;
  logic                   vs_prev;
  logic                   vsync_start;
  logic [2:0]             offset;
  logic [13:0]            addr_ext;
  logic [13:0]            base_lo;
  logic [13:0]            base_hi;
  logic                   shadow_wr;
  logic                   ctrl_req;
  logic                   set_pending;
  logic                   commit;
  logic [31:0]            status;

  // Address decode: full range compare for hit, low bits for the offset.
  assign addr_ext = {1'b0, address};
  assign base_lo  = {1'b0, BASE_ADDR};
  assign base_hi  = base_lo + 14'd7;
  assign hit      = (addr_ext >= base_lo) && (addr_ext <= base_hi);
  assign offset   = address[2:0] - BASE_ADDR[2:0];

  assign shadow_wr   = wren && hit && (offset < 3'd6);
  assign ctrl_req    = wren && hit && (offset == 3'd6) && data_in[0];
`ifdef SPRITE_AUTO_COMMIT_EN
  assign set_pending = ctrl_req || shadow_wr;
`else
  assign set_pending = ctrl_req;
`endif

  assign vsync_start = vs_prev && !vs_sync[SYNC_STAGES-1];
  assign commit      = (state == PENDING) && vsync_start;
  assign status      = {15'b0, (state == PENDING), frame_cnt};

  // Synchronize the active-low vsync and keep the previous synced value.
  always_ff @(posedge clock) begin
    if (!reset) begin
      vs_sync <= '1;
      vs_prev <= 1'b1;
    end else begin
      vs_sync <= {vs_sync[SYNC_STAGES-2:0], vga_vs};
      vs_prev <= vs_sync[SYNC_STAGES-1];
    end
  end

  // Shadow register writes from the processor.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 6; i++) shadow[i] <= '0;
    end else if (shadow_wr) begin
      shadow[offset] <= data_in;
    end
  end

  // Registered read port.
  always_ff @(posedge clock) begin
    if (!reset) begin
      data_out <= '0;
    end else if (!hit) begin
      data_out <= '0;
    end else begin
      case (offset)
        3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5: data_out <= shadow[offset];
        3'd7:                               data_out <= status;
        default:                            data_out <= '0;
      endcase
    end
  end

  // Commit FSM with frame counter, tick and active descriptor registers.
  // A request in the commit cycle wins over the return to IDLE, and the
  // copy reads the shadows before any same-edge write lands.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      frame_cnt  <= '0;
      frame_tick <= 1'b0;
      p1VGA      <= '0;
      p2VGA      <= '0;
      stageVGA   <= '0;
    end else begin
      frame_tick <= vsync_start;
      if (vsync_start) frame_cnt <= frame_cnt + 16'd1;
      if (commit) begin
        p1VGA    <= {shadow[0], shadow[1]};
        p2VGA    <= {shadow[2], shadow[3]};
        stageVGA <= {shadow[4], shadow[5]};
      end
      case (state)
        IDLE:    if (set_pending) state <= PENDING;
        PENDING: if (vsync_start && !set_pending) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_desc_writer.sv
// Directed self-checking bench for sprite_desc_writer (default parameters).
module tb_sprite_desc_writer;

  localparam logic [12:0] BASE = 13'h1F00;

  logic        clock;
  logic        reset;
  logic [12:0] address;
  logic [31:0] data_in;
  logic        wren;
  logic        hit;
  logic [31:0] data_out;
  logic        vga_vs;
  logic [63:0] p1VGA;
  logic [63:0] p2VGA;
  logic [63:0] stageVGA;
  logic        frame_tick;

  int unsigned checks;
  int unsigned errors;
  logic [31:0] rdata;

  sprite_desc_writer #(.BASE_ADDR(13'h1F00), .SYNC_STAGES(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .address    (address),
    .data_in    (data_in),
    .wren       (wren),
    .hit        (hit),
    .data_out   (data_out),
    .vga_vs     (vga_vs),
    .p1VGA      (p1VGA),
    .p2VGA      (p2VGA),
    .stageVGA   (stageVGA),
    .frame_tick (frame_tick)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] d);
    @(negedge clock);
    address = BASE + {10'd0, off};
    data_in = d;
    wren    = 1'b1;
    @(negedge clock);
    wren    = 1'b0;
    address = '0;
    data_in = '0;
  endtask

  task automatic rd(input logic [2:0] off, output logic [31:0] d);
    @(negedge clock);
    address = BASE + {10'd0, off};
    @(negedge clock);
    d       = data_out;
    address = '0;
  endtask

  // Falling edge of vga_vs; tick is expected in the cycle after the third edge.
  task automatic vs_pulse(input string tag);
    @(negedge clock);
    vga_vs = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check({tag, "_tick_early"}, {63'd0, frame_tick}, 64'd0);
    @(negedge clock);
    check({tag, "_tick"}, {63'd0, frame_tick}, 64'd1);
    vga_vs = 1'b1;
    @(negedge clock);
    check({tag, "_tick_once"}, {63'd0, frame_tick}, 64'd0);
    repeat (3) @(negedge clock);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b0;
    wren    = 1'b1;
    address = BASE;
    data_in = '1;
    vga_vs  = 1'b1;
    repeat (3) @(negedge clock);
    reset   = 1'b1;
    wren    = 1'b0;
    address = '0;
    data_in = '0;

    // Reset state
    check("rst_p1", p1VGA, 64'd0);
    check("rst_p2", p2VGA, 64'd0);
    check("rst_st", stageVGA, 64'd0);
    check("rst_tick", {63'd0, frame_tick}, 64'd0);
    check("rst_dout", {32'd0, data_out}, 64'd0);
    rd(3'd7, rdata); check("rst_status", {32'd0, rdata}, 64'd0);
    rd(3'd0, rdata); check("rst_shadow0", {32'd0, rdata}, 64'd0);

    // Staged write without commit
    wr(3'd0, 32'h00C8_00C8);
    wr(3'd1, 32'h0064_0064);
    rd(3'd0, rdata); check("rd_p1hi", {32'd0, rdata}, 64'h0000_0000_00C8_00C8);
    rd(3'd1, rdata); check("rd_p1lo", {32'd0, rdata}, 64'h0000_0000_0064_0064);
    vs_pulse("v1");
`ifdef SPRITE_AUTO_COMMIT_EN
    check("stage_p1", p1VGA, 64'h00C8_00C8_0064_0064);
`else
    check("stage_p1", p1VGA, 64'd0);
`endif
    rd(3'd7, rdata); check("status_1", {32'd0, rdata}, 64'h0000_0001);

    // Explicit commit
    wr(3'd6, 32'h0000_0001);
    rd(3'd7, rdata); check("status_pend", {32'd0, rdata}, 64'h0001_0001);
    vs_pulse("v2");
    check("commit_p1", p1VGA, 64'h00C8_00C8_0064_0064);
    rd(3'd7, rdata); check("status_2", {32'd0, rdata}, 64'h0000_0002);

    // Known stage and p2 values
    wr(3'd2, 32'h0005_0006);
    wr(3'd3, 32'h0007_0008);
    wr(3'd4, 32'h0011_0022);
    wr(3'd5, 32'h0033_0044);
    wr(3'd6, 32'h0000_0001);
    vs_pulse("v3");
    check("commit_p2", p2VGA, 64'h0005_0006_0007_0008);
    check("commit_st", stageVGA, 64'h0011_0022_0033_0044);
    check("hold_p1", p1VGA, 64'h00C8_00C8_0064_0064);

    // Collision: ST_HI write sampled at the commit edge
    wr(3'd6, 32'h0000_0001);
    @(negedge clock);
    vga_vs = 1'b0;
    @(negedge clock);
    @(negedge clock);
    address = BASE + 13'd4;
    data_in = 32'h0190_0190;
    wren    = 1'b1;
    @(negedge clock);
    wren    = 1'b0;
    address = '0;
    data_in = '0;
    check("coll_tick", {63'd0, frame_tick}, 64'd1);
    check("coll_st", stageVGA, 64'h0011_0022_0033_0044);
    vga_vs = 1'b1;
    repeat (4) @(negedge clock);
    rd(3'd4, rdata); check("coll_shadow", {32'd0, rdata}, 64'h0000_0000_0190_0190);
    rd(3'd7, rdata);
`ifdef SPRITE_AUTO_COMMIT_EN
    check("coll_status", {32'd0, rdata}, 64'h0001_0004);
`else
    check("coll_status", {32'd0, rdata}, 64'h0000_0004);
`endif
    vs_pulse("v5");
`ifdef SPRITE_AUTO_COMMIT_EN
    check("coll_next_st", stageVGA, 64'h0190_0190_0033_0044);
`else
    check("coll_next_st", stageVGA, 64'h0011_0022_0033_0044);
`endif
    wr(3'd6, 32'h0000_0001);
    vs_pulse("v6");
    check("coll_commit_st", stageVGA, 64'h0190_0190_0033_0044);
    rd(3'd7, rdata); check("status_6", {32'd0, rdata}, 64'h0000_0006);

    // Decode boundaries
    @(negedge clock);
    address = BASE + 13'd8; #1 check("hit_above", {63'd0, hit}, 64'd0);
    address = BASE - 13'd1; #1 check("hit_below", {63'd0, hit}, 64'd0);
    address = BASE + 13'd7; #1 check("hit_top", {63'd0, hit}, 64'd1);
    address = BASE;         #1 check("hit_base", {63'd0, hit}, 64'd1);
    @(negedge clock);
    address = BASE + 13'd8;
    data_in = 32'hDEAD_BEEF;
    wren    = 1'b1;
    @(negedge clock);
    check("dout_miss", {32'd0, data_out}, 64'd0);
    address = BASE - 13'd1;
    @(negedge clock);
    wren    = 1'b0;
    address = '0;
    wr(3'd7, 32'hFFFF_FFFF);
    rd(3'd0, rdata); check("miss_shadow0", {32'd0, rdata}, 64'h0000_0000_00C8_00C8);
    rd(3'd5, rdata); check("miss_shadow5", {32'd0, rdata}, 64'h0000_0000_0033_0044);
    rd(3'd7, rdata); check("miss_status", {32'd0, rdata}, 64'h0000_0006);
    rd(3'd6, rdata); check("rd_ctrl", {32'd0, rdata}, 64'd0);

    // Frame counter wrap, preloaded near the top
    @(negedge clock);
    force dut.frame_cnt = 16'hFFFE;
    @(negedge clock);
    release dut.frame_cnt;
    rd(3'd7, rdata); check("preload", {32'd0, rdata}, 64'h0000_FFFE);
    vs_pulse("w1");
    rd(3'd7, rdata); check("cnt_ffff", {32'd0, rdata}, 64'h0000_FFFF);
    vs_pulse("w2");
    rd(3'd7, rdata); check("cnt_wrap", {32'd0, rdata}, 64'h0000_0000);

    // Reset while a commit is pending
    wr(3'd6, 32'h0000_0001);
    rd(3'd7, rdata); check("pend_pre_rst", {32'd0, rdata}, 64'h0001_0000);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    check("rr_p1", p1VGA, 64'd0);
    vs_pulse("r1");
    check("rr_p1_post", p1VGA, 64'd0);
    check("rr_p2_post", p2VGA, 64'd0);
    check("rr_st_post", stageVGA, 64'd0);
    rd(3'd7, rdata); check("rr_status", {32'd0, rdata}, 64'h0000_0001);
    rd(3'd0, rdata); check("rr_shadow0", {32'd0, rdata}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_desc_writer.md
# sprite_desc_writer

Processor-side producer of the packed sprite descriptors (`p1VGA`, `p2VGA`, `stageVGA`) consumed by `vga_controller`. It decodes memory-mapped word writes from the processor data port into shadow registers. It transfers all shadows to the active outputs atomically at the start of vertical sync, so the VGA side never sees a half-updated frame. It sits beside `mmio` on the dmem bus, and its outputs drive the VGA descriptor inputs directly.

## Interface
- `BASE_ADDR`, default 13'h1F00: word address of register 0; block occupies BASE_ADDR..BASE_ADDR+7.
- `SYNC_STAGES`, default 2: synchronizer flops on `vga_vs`; legal range 2..4.
- `clock`  in  1: processor clock; all state on rising edge.
- `reset`  in  1: synchronous, active-low; sampled on rising edge of `clock`.
- `address`  in  13: dmem word address.
- `data_in`  in  32: write data.
- `wren`  in  1: write strobe, one cycle per write.
- `hit`  out  1: combinational; high when `address` is in BASE_ADDR..BASE_ADDR+7.
- `data_out`  out  32: registered read data.
- `vga_vs`  in  1: VGA_VS from the VGA clock domain, active-low, asynchronous to `clock`.
- `p1VGA`, `p2VGA`, `stageVGA`  out  64 each: active descriptors.
- `frame_tick`  out  1: one-cycle pulse per detected vsync start.

## Operation
- Descriptor format: [63:48] x, [47:32] y, [31:16] width, [15:0] height; all fields unsigned 16-bit, with no clamping.
- Register map, offset = address − BASE_ADDR:
  - 0: P1_HI (x,y).
  - 1: P1_LO (w,h).
  - 2: P2_HI.
  - 3: P2_LO.
  - 4: ST_HI.
  - 5: ST_LO.
  - 6: CTRL; write bit0=1 requests commit, other bits ignored.
  - 7: STATUS; read-only, {15'b0, pending, frame_cnt[15:0]}.
- Writes with `wren` & `hit` update the addressed shadow word. Writes to offset 7 and writes with `hit`=0 are ignored.
- Reads: on every cycle, `data_out` ← value at `address` (shadow for offsets 0–5, 0 for 6, STATUS for 7) if `hit`; otherwise 0.
- Commit FSM, two states:
  - IDLE: CTRL write with bit0=1 → PENDING.
  - PENDING: vsync start → copy all six shadow words to the outputs in one cycle → IDLE.
- Vsync start: `vga_vs` passed through SYNC_STAGES flops, then falling-edge detect (previous synced =1, current =0).
- On every vsync start, in either state:
  - `frame_tick`=1 for one cycle.
  - `frame_cnt` increments, wrapping 16'hFFFF→0.
- Simultaneous events:
  - Shadow write in the commit cycle: the commit copies the pre-write shadow; the new value waits for a later commit.
  - CTRL commit request in the commit cycle: FSM stays/returns PENDING, and the next vsync commits again.
- Reset mid-operation (including PENDING): everything returns to reset values next edge; synchronizer flops reset to 1.

## Timing
- Reset values:
  - `p1VGA`, `p2VGA`, `stageVGA` = 64'h0.
  - All shadows = 0.
  - `data_out` = 0.
  - `frame_tick` = 0.
  - FSM = IDLE, `frame_cnt` = 0.
- `hit`: combinational, same cycle as `address`.
- Read latency: 1 cycle (`data_out` valid the edge after `address` is presented).
- Write latency: shadow updated at the edge where `wren` is sampled; readable at the next read.
- Vsync latency: `vga_vs` falling edge settled before edge k → `frame_tick` high and outputs updated in the cycle after edge k+SYNC_STAGES. Default: 3 edges after first sampled low.
- Outputs change only in the commit cycle and hold otherwise. They are stable throughout active video and are therefore safe to sample from the VGA domain.

## Configuration
- `SPRITE_AUTO_COMMIT_EN` defined:
  - Any shadow write (offsets 0–5) also moves the FSM to PENDING, so software need not write CTRL.
  - The same-cycle rule still applies: a write in the commit cycle leaves the FSM PENDING.
- Not defined: only a CTRL bit0 write sets PENDING; shadow writes alone never reach the outputs.

## Test plan
- Reset: hold `reset`=0 for 3 cycles with `wren`=1 → all outputs 0, STATUS reads 0.
- Staged write, no commit: write P1_HI=32'h00C8_00C8, P1_LO=32'h0064_0064, pulse `vga_vs` low → `p1VGA` stays 0; read offset 0 returns 32'h00C8_00C8; STATUS = 1. With `SPRITE_AUTO_COMMIT_EN`: `p1VGA`=64'h00C8_00C8_0064_0064.
- Commit: then write CTRL=1 → STATUS bit16=1; `vga_vs` falling edge → 3 edges later `p1VGA`=64'h00C8_00C8_0064_0064, `frame_tick` one pulse, STATUS = 32'h0000_0002.
- Collision: write ST_HI=32'h0190_0190 in the exact commit cycle → `stageVGA`[63:32] keeps its old value; with auto-commit, the next vsync shows 0190_0190.
- Wrap and decode: preload 65535 vsyncs → next vsync gives frame_cnt=0. Write to BASE_ADDR+8 and BASE_ADDR−1 → `hit`=0 and no state change.
- Reset in PENDING: request commit, assert `reset` before vsync, release, pulse vsync → outputs remain 0.
